// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Brief    : MIPS opcode/funct constants, request kinds and encoder FSM states.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

  localparam logic [5:0] c_op_r      = 6'd0;
  localparam logic [5:0] c_op_lw     = 6'd35;
  localparam logic [5:0] c_op_sw     = 6'd43;
  localparam logic [5:0] c_op_j      = 6'd2;
  localparam logic [5:0] c_funct_add = 6'd32;
  localparam logic [5:0] c_funct_sub = 6'd34;

  typedef enum logic [2:0] {
    KIND_ADD = 3'd0,
    KIND_SUB = 3'd1,
    KIND_LW  = 3'd2,
    KIND_SW  = 3'd3,
    KIND_J   = 3'd4
  } kind_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // J-format word from a word index (byte address bits [27:2]).
  function automatic logic [31:0] jump_word(input logic [25:0] word_idx);
    return {c_op_j, word_idx};
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_pack.sv
`default_nettype none
// ============================================================================
// Module   : instr_pack
// Brief    : Combinational request-fields to 32-bit MIPS word, plus illegal flag.
// Revision : 1.0 - initial release
// ============================================================================
module instr_pack
  import mips_pkg::*;
(
  input  logic [2:0]  i_kind,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_rd,
  input  logic [15:0] i_imm,
  input  logic [31:0] i_target,
  output logic [31:0] o_word,
  output logic        o_illegal
);

  logic w_unused;
  assign w_unused = ^i_target[31:28];

  always_comb begin
    o_word    = 32'd0;
    o_illegal = 1'b0;
    case (i_kind)
      KIND_ADD: o_word = {c_op_r, i_rs, i_rt, i_rd, 5'd0, c_funct_add};
      KIND_SUB: o_word = {c_op_r, i_rs, i_rt, i_rd, 5'd0, c_funct_sub};
      KIND_LW:  o_word = {c_op_lw, i_rs, i_rt, i_imm};
      KIND_SW:  o_word = {c_op_sw, i_rs, i_rt, i_imm};
      KIND_J: begin
        o_word    = jump_word(i_target[27:2]);
        o_illegal = |i_target[1:0];
      end
      default:  o_illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder
// Brief    : Sequentially writes encoded MIPS requests into imem, closing with a self-loop halt.
// Revision : 1.0 - initial release
// ============================================================================
module instr_encoder
  import mips_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [31:0]       in_target,
  output logic              wr_en,
  output logic [31:0]       wr_addr,
  output logic [31:0]       wr_data,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int               CNT_W       = ADDR_W + 1;
  localparam logic [CNT_W-1:0] c_last_slot = CNT_W'(DEPTH - 1);

  state_e             r_state;
  logic [CNT_W-1:0]   r_count;
  logic               r_wr_en;
  logic [31:0]        r_wr_addr;
  logic [31:0]        r_wr_data;
  logic               r_done;
  logic               r_err;

  logic [31:0]        w_word;
  logic               w_illegal;
  logic               w_accept;
  logic [31:0]        w_slot_addr;
  logic               w_unused;

  instr_pack u_pack (
    .i_kind    (in_kind),
    .i_rs      (in_rs),
    .i_rt      (in_rt),
    .i_rd      (in_rd),
    .i_imm     (in_imm),
    .i_target  (in_target),
    .o_word    (w_word),
    .o_illegal (w_illegal)
  );

  // The last slot is held back so the halt word always fits.
  assign in_ready    = (r_state == ST_RUN) && (r_count < c_last_slot);
  assign w_accept    = in_valid && in_ready;
  assign w_slot_addr = BASE_ADDR + (32'(r_count) << 2);
  assign w_unused    = ^{w_slot_addr[31:28], w_slot_addr[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= 32'd0;
      r_wr_data <= 32'd0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state <= ST_RUN;
            r_count <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            if (w_illegal) begin
              r_err <= 1'b1;
            end else begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= w_slot_addr;
              r_wr_data <= w_word;
              r_count   <= r_count + CNT_W'(1);
            end
          end
          if (finish) r_state <= ST_HALT;
        end
        ST_HALT: begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= w_slot_addr;
          r_wr_data <= jump_word(w_slot_addr[27:2]);
          r_count   <= r_count + CNT_W'(1);
          r_done    <= 1'b1;
          r_state   <= ST_DONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign count   = r_count;
  assign busy    = (r_state == ST_RUN) || (r_state == ST_HALT);
  assign done    = r_done;
  assign err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_encoder
// Brief    : Directed bench for instr_encoder (DEPTH 256 and DEPTH 4 side by side).
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        finish = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  in_kind = 3'd0;
  logic [4:0]  in_rs = 5'd0, in_rt = 5'd0, in_rd = 5'd0;
  logic [15:0] in_imm = 16'd0;
  logic [31:0] in_target = 32'd0;

  logic        rdy0, rdy1, wen0, wen1, busy0, busy1, done0, done1, err0, err1;
  logic [31:0] wa0, wa1, wd0, wd1;
  logic [8:0]  cnt0;
  logic [2:0]  cnt1;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(8), .DEPTH(256), .BASE_ADDR(32'd0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .finish(finish), .in_valid(in_valid), .in_ready(rdy0),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_target(in_target), .wr_en(wen0), .wr_addr(wa0), .wr_data(wd0), .count(cnt0),
    .busy(busy0), .done(done0), .err(err0)
  );

  instr_encoder #(.ADDR_W(2), .DEPTH(4), .BASE_ADDR(32'd0)) dut1 (
    .clk(clk), .rst(rst), .start(start), .finish(finish), .in_valid(in_valid), .in_ready(rdy1),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_target(in_target), .wr_en(wen1), .wr_addr(wa1), .wr_data(wd1), .count(cnt1),
    .busy(busy1), .done(done1), .err(err1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 running, 2 halting, 3 done.
  int          depth[2] = '{256, 4};
  int          m_phase[2] = '{0, 0};
  longint      m_count[2] = '{0, 0};
  bit          m_err[2] = '{0, 0};
  bit          m_done[2] = '{0, 0};
  bit          m_wen[2] = '{0, 0};
  logic [31:0] m_waddr[2] = '{32'd0, 32'd0};
  logic [31:0] m_wdata[2] = '{32'd0, 32'd0};

  function automatic logic [31:0] enc(input longint kind, input longint rs, input longint rt,
                                      input longint rd, input longint imm, input longint tgt);
    longint w;
    case (kind)
      0:       w = rs * 2**21 + rt * 2**16 + rd * 2**11 + 32;
      1:       w = rs * 2**21 + rt * 2**16 + rd * 2**11 + 34;
      2:       w = 35 * 64'd67108864 + rs * 2**21 + rt * 2**16 + imm;
      3:       w = 43 * 64'd67108864 + rs * 2**21 + rt * 2**16 + imm;
      default: w = 2 * 64'd67108864 + (tgt % 2**28) / 4;
    endcase
    return w[31:0];
  endfunction

  function automatic bit exp_ready(input int k);
    return (m_phase[k] == 1) && (m_count[k] < depth[k] - 1);
  endfunction

  task automatic model_step(input int k);
    bit     legal;
    longint addr;
    bit     rdy;
    rdy = exp_ready(k);
    m_wen[k] = 1'b0;
    if (rst) begin
      m_phase[k] = 0; m_count[k] = 0; m_err[k] = 0; m_done[k] = 0;
      m_waddr[k] = 32'd0; m_wdata[k] = 32'd0;
    end else if (m_phase[k] == 0 || m_phase[k] == 3) begin
      if (start) begin
        m_phase[k] = 1; m_count[k] = 0; m_err[k] = 0; m_done[k] = 0;
      end
    end else if (m_phase[k] == 1) begin
      if (in_valid && rdy) begin
        legal = (in_kind <= 3) || (in_kind == 4 && (in_target % 4) == 0);
        if (legal) begin
          m_wen[k]   = 1'b1;
          m_waddr[k] = 32'(4 * m_count[k]);
          m_wdata[k] = enc(longint'(in_kind), longint'(in_rs), longint'(in_rt),
                           longint'(in_rd), longint'(in_imm), longint'(in_target));
          m_count[k]++;
        end else begin
          m_err[k] = 1'b1;
        end
      end
      if (finish) m_phase[k] = 2;
    end else begin
      addr       = 4 * m_count[k];
      m_wen[k]   = 1'b1;
      m_waddr[k] = 32'(addr);
      m_wdata[k] = enc(4, 0, 0, 0, 0, addr);
      m_count[k]++;
      m_phase[k] = 3;
      m_done[k]  = 1'b1;
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) model_step(k);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("d0.in_ready", 32'(rdy0),  32'(exp_ready(0)));
      chk("d0.wr_en",    32'(wen0),  32'(m_wen[0]));
      chk("d0.wr_addr",  wa0,        m_waddr[0]);
      chk("d0.wr_data",  wd0,        m_wdata[0]);
      chk("d0.count",    32'(cnt0),  32'(m_count[0]));
      chk("d0.busy",     32'(busy0), 32'(m_phase[0] == 1 || m_phase[0] == 2));
      chk("d0.done",     32'(done0), 32'(m_done[0]));
      chk("d0.err",      32'(err0),  32'(m_err[0]));
      chk("d1.in_ready", 32'(rdy1),  32'(exp_ready(1)));
      chk("d1.wr_en",    32'(wen1),  32'(m_wen[1]));
      chk("d1.wr_addr",  wa1,        m_waddr[1]);
      chk("d1.wr_data",  wd1,        m_wdata[1]);
      chk("d1.count",    32'(cnt1),  32'(m_count[1]));
      chk("d1.busy",     32'(busy1), 32'(m_phase[1] == 1 || m_phase[1] == 2));
      chk("d1.done",     32'(done1), 32'(m_done[1]));
      chk("d1.err",      32'(err1),  32'(m_err[1]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic req(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] rd, input logic [15:0] imm, input logic [31:0] tgt);
    in_valid = 1'b1; in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd;
    in_imm = imm; in_target = tgt;
  endtask

  task automatic close_and_restart();
    finish = 1'b1; tick(); finish = 1'b0; tick();
    start = 1'b1;  tick(); start = 1'b0;
  endtask

  initial begin
    tick();
    chk_en = 1'b1;
    chk("rst.wr_en", 32'(wen0), 32'd0);
    chk("rst.wr_addr", wa0, 32'd0);
    chk("rst.wr_data", wd0, 32'd0);
    chk("rst.count", 32'(cnt0), 32'd0);
    chk("rst.flags", {28'd0, rdy0, busy0, done0, err0}, 32'd0);
    tick();
    rst = 1'b0;
    start = 1'b1; tick(); start = 1'b0;

    req(3'd0, 5'd1, 5'd2, 5'd3, 16'd0, 32'd0); tick(); in_valid = 1'b0;
    chk("add.wr_en", 32'(wen0), 32'd1);
    chk("add.wr_addr", wa0, 32'd0);
    chk("add.wr_data", wd0, 32'h0022_1820);
    chk("add.count", 32'(cnt0), 32'd1);

    close_and_restart();
    req(3'd2, 5'd4, 5'd5, 5'd0, 16'hFFFC, 32'd0); tick();
    chk("lw.wr_data", wd0, 32'h8C85_FFFC);
    chk("lw.wr_addr", wa0, 32'd0);
    req(3'd3, 5'd4, 5'd5, 5'd0, 16'hFFFC, 32'd0); tick(); in_valid = 1'b0;
    chk("sw.wr_data", wd0, 32'hAC85_FFFC);
    chk("sw.wr_addr", wa0, 32'd4);
    chk("sw.count", 32'(cnt0), 32'd2);

    close_and_restart();
    req(3'd4, 5'd0, 5'd0, 5'd0, 16'd0, 32'h40); finish = 1'b1; tick();
    in_valid = 1'b0; finish = 1'b0;
    chk("j.wr_data", wd0, 32'h0800_0010);
    chk("j.wr_addr", wa0, 32'd0);
    tick();
    chk("halt.wr_data", wd0, 32'h0800_0001);
    chk("halt.wr_addr", wa0, 32'd4);
    chk("halt.done", 32'(done0), 32'd1);
    chk("halt.count", 32'(cnt0), 32'd2);
    chk("halt.in_ready", 32'(rdy0), 32'd0);

    start = 1'b1; tick(); start = 1'b0;
    req(3'd6, 5'd1, 5'd1, 5'd1, 16'd1, 32'd0); tick();
    chk("ill.wr_en", 32'(wen0), 32'd0);
    chk("ill.err", 32'(err0), 32'd1);
    req(3'd4, 5'd0, 5'd0, 5'd0, 16'd0, 32'h42); tick(); in_valid = 1'b0;
    chk("mis.wr_en", 32'(wen0), 32'd0);
    chk("mis.count", 32'(cnt0), 32'd0);
    close_and_restart();
    chk("restart.err", 32'(err0), 32'd0);

    for (int i = 0; i < 4; i++) begin
      req(3'd0, 5'(i), 5'(i + 1), 5'(i + 2), 16'd0, 32'd0); tick();
    end
    in_valid = 1'b0;
    chk("full.count", 32'(cnt1), 32'd3);
    chk("full.in_ready", 32'(rdy1), 32'd0);
    finish = 1'b1; tick(); finish = 1'b0; tick();
    chk("full.halt_addr", wa1, 32'd12);
    chk("full.halt_data", wd1, 32'h0800_0003);
    chk("full.halt_count", 32'(cnt1), 32'd4);

    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      in_valid  = (i % 3) != 2;
      in_kind   = 3'(i % 8);
      in_rs     = 5'(i + 3);
      in_rt     = 5'(31 - i);
      in_rd     = 5'(i * 2);
      in_imm    = 16'(i * 4097);
      in_target = 32'(i * 32'h1234_5670);
      tick();
    end
    in_valid = 1'b0;
    finish = 1'b1; tick(); finish = 1'b0; tick();

    start = 1'b1; tick(); start = 1'b0;
    req(3'd0, 5'd1, 5'd2, 5'd3, 16'd0, 32'd0); tick();
    rst = 1'b1; tick(); rst = 1'b0; in_valid = 1'b0;
    chk("rstrun.wr_en", 32'(wen0), 32'd0);
    chk("rstrun.count", 32'(cnt0), 32'd0);
    chk("rstrun.wr_addr", wa0, 32'd0);
    chk("rstrun.busy", 32'(busy0), 32'd0);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
